polar64_crc16_encoder: RTL
==========================

# polar64_crc16_encoder

Multi-cycle encoder for the 64-bit polar code with 24 data bits and 16 CRC bits. It computes CRC-16-CCITT over a 24-bit data word and maps data and CRC onto the information positions, with frozen positions held at 0. It then applies the 64-point polar transform in six butterfly stages and returns the codeword with a one-cycle `done` pulse. It sits on the transmit side and produces codewords that `polar64_crc16_decoder` accepts at distance 0.

## Interface
Parameters: none. All code constants come from `polar_common_pkg`.

Ports:
- `clk` — input, 1 bit. Single clock.
- `rst` — input, 1 bit. Reset, synchronous and active-high.
- `start` — input, 1 bit. Request to encode; sampled only while `ready`=1.
- `data_in` — input, 24 bits. Payload, MSB-first; captured on the accepting edge.
- `ready` — output, 1 bit. High when idle and able to accept `start`.
- `done` — output, 1 bit. One-cycle pulse; `codeword` is valid from this cycle on.
- `codeword` — output, 64 bits. Encoded word; holds its value until the next `done`.

## Operation
- FSM states: IDLE → CRC → MAP → XFORM → IDLE.
- **IDLE**
  - `ready`=1.
  - When `start`=1: latch `data_in`, load the CRC register with `CRC_INIT`, clear the byte counter, go to CRC.
- **CRC**
  - 8 data bits per cycle, MSB byte first; polynomial 0x1021, MSB-first shift.
  - 3 cycles.
  - The final 16-bit value must be bit-exact to `crc16_ccitt24(data)`.
- **MAP** (1 cycle): build the 64-bit u vector.
  - `u[INFO_POS[k]] = data[23-k]` for k = 0..23.
  - `u[INFO_POS[24+k]] = crc[15-k]` for k = 0..15.
  - All `FROZEN_POS` entries are 0.
- **XFORM** (6 cycles, stage counter s = 0..5).
  - For every index i with bit s = 0: `x[i] <= x[i] ^ x[i + 2^s]`; `x[i + 2^s]` is unchanged.
  - The result after stage 5 must equal `polar_transform64(u)`. Stage order does not affect the result.
- After stage 5: register the result into `codeword`, pulse `done`, return to IDLE.
- `start` is ignored while `ready`=0. No queuing; `data_in` is only sampled on the accepting edge.
- **Reset** (synchronous, takes priority in any state, including mid-operation):
  - Next state is IDLE.
  - `ready`=1, `done`=0, `codeword`=0.
  - Internal data, CRC, stage and counter registers are cleared.
  - No `done` is produced for an aborted word.

## Timing
- Let edge E0 be the edge that samples `start`=1 while `ready`=1.
  - `ready` falls after E0.
  - `done`=1 and the new `codeword` appear after edge E0+10 (11th cycle).
  - `ready`=1 in that same cycle.
- `done` is exactly one cycle wide.
- `start` asserted during the `done` cycle is accepted (back-to-back). Sustained throughput is one word per 11 cycles.
- Latency is fixed and independent of data.

## Configuration
- Macro: `POLAR64_ENC_FAST_XFORM_EN`.
- **Defined:** XFORM is a single cycle that applies all six stages combinationally. Latency drops to `done` after E0+5 (6th cycle); back-to-back throughput is one word per 6 cycles. All other behaviour is identical.
- **Undefined (default):** six-cycle staged XFORM as described in Operation.

## Structure
- `polar_common_pkg` owns the shared code definitions:
  - `K_DATA`, `K_CRC`, `K_FRZ`, `INFO_POS`, `FROZEN_POS`, `CRC_INIT`, `CRC_POLY`.
  - The reference functions `crc16_ccitt24` and `polar_transform64`.
  - A new function `polar_stage64(x, s)` for one butterfly stage.
  - A new enum `polar_enc_state_t` for the FSM states.
- The encoder uses the package functions only for bench checking and stage logic, never as a single-cycle shortcut, except when `POLAR64_ENC_FAST_XFORM_EN` is defined.
- One sub-module: `crc16_ccitt_byte` (combinational; current CRC plus 8 bits → next CRC), instantiated once.

## Test plan
1. Reset mid-encode: `rst`=1 at E0+4 → next cycle `ready`=1, `done`=0, `codeword`=64'h0; no `done` at E0+10.
2. Basic encode: `data_in`=24'hA5C3E1 → `done` after E0+10. `codeword` == `polar_transform64` of the mapped u vector. Feeding that codeword to `polar64_crc16_decoder` gives `valid`=1, `data_out`=24'hA5C3E1.
3. Boundary data: 24'h000000 and 24'hFFFFFF each match the reference model. Re-transforming `codeword` gives 0 at all 24 `FROZEN_POS`.
4. Back-to-back and busy `start`:
   - `start` held high continuously with 24'h123456 then 24'hFEDCBA → `done` at E0+10 and E0+21 with the correct codewords.
   - `start` pulses during busy cycles are ignored.
5. Error tolerance: encode 24'h0F0F0F, flip bits 0, 31 and 63 → decoder gives `valid`=1, `data_out`=24'h0F0F0F.
6. With `POLAR64_ENC_FAST_XFORM_EN` defined: rerun scenarios 2–4 with `done` expected after E0+5 and identical codewords.

Source files
------------

// File: rtl/polar_common_pkg.sv
// Shared code definitions for the 64-bit polar code with 24 data bits and CRC-16-CCITT:
// information/frozen position sets, CRC constants, reference functions and the encoder FSM states.
package polar_common_pkg;

    localparam int K_DATA = 24;
    localparam int K_CRC  = 16;
    localparam int K_INFO = K_DATA + K_CRC;
    localparam int K_FRZ  = 24;
    localparam int N_CODE = 64;

    localparam logic [15:0] CRC_INIT = 16'hFFFF;
    localparam logic [15:0] CRC_POLY = 16'h1021;

    // Most reliable 40 indices (highest index weight), ascending; data first, CRC last.
    localparam logic [5:0] INFO_POS [K_INFO] = '{
        6'd13, 6'd14, 6'd15, 6'd19, 6'd21, 6'd22, 6'd23, 6'd25, 6'd26, 6'd27,
        6'd28, 6'd29, 6'd30, 6'd31, 6'd35, 6'd37, 6'd38, 6'd39, 6'd41, 6'd42,
        6'd43, 6'd44, 6'd45, 6'd46, 6'd47, 6'd49, 6'd50, 6'd51, 6'd52, 6'd53,
        6'd54, 6'd55, 6'd56, 6'd57, 6'd58, 6'd59, 6'd60, 6'd61, 6'd62, 6'd63
    };

    localparam logic [5:0] FROZEN_POS [K_FRZ] = '{
        6'd0,  6'd1,  6'd2,  6'd3,  6'd4,  6'd5,  6'd6,  6'd7,  6'd8,  6'd9,
        6'd10, 6'd11, 6'd12, 6'd16, 6'd17, 6'd18, 6'd20, 6'd24, 6'd32, 6'd33,
        6'd34, 6'd36, 6'd40, 6'd48
    };

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_CRC,
        ST_MAP,
        ST_XFORM
    } polar_enc_state_t;

    function automatic logic [15:0] crc16_ccitt24(input logic [23:0] data);
        logic [15:0] crc;
        logic        fb;
        crc = CRC_INIT;
        for (int i = 0; i < K_DATA; i++) begin
            fb  = crc[15] ^ data[K_DATA-1-i];
            crc = {crc[14:0], 1'b0} ^ (fb ? CRC_POLY : 16'h0000);
        end
        return crc;
    endfunction

    // One butterfly stage: lower index of each pair absorbs its partner 2^s above.
    function automatic logic [63:0] polar_stage64(input logic [63:0] x, input logic [2:0] s);
        logic [63:0] y;
        y = x;
        for (int i = 0; i < N_CODE; i++) begin
            if (((i >> s) & 1) == 0)
                y[i] = x[i] ^ x[i | (1 << s)];
        end
        return y;
    endfunction

    function automatic logic [63:0] polar_transform64(input logic [63:0] u);
        logic [63:0] x;
        x = u;
        for (int s = 0; s < 6; s++)
            x = polar_stage64(x, 3'(s));
        return x;
    endfunction

endpackage

// File: rtl/crc16_ccitt_byte.sv
// Combinational CRC-16-CCITT update over one byte, MSB-first.
module crc16_ccitt_byte
    import polar_common_pkg::*;
(
    input  logic [15:0] crc_i,
    input  logic [7:0]  byte_i,
    output logic [15:0] crc_o
);

    always_comb begin
        logic [15:0] c;
        logic        fb;
        c = crc_i;
        for (int i = 7; i >= 0; i--) begin
            fb = c[15] ^ byte_i[i];
            c  = {c[14:0], 1'b0} ^ (fb ? CRC_POLY : 16'h0000);
        end
        crc_o = c;
    end

endmodule

// File: rtl/polar64_crc16_encoder.sv
// Multi-cycle polar(64,24)+CRC16 encoder: CRC (3 cycles), MAP, staged XFORM, one-cycle done.
// POLAR64_ENC_FAST_XFORM_EN collapses XFORM into a single combinational cycle.
module polar64_crc16_encoder
    import polar_common_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic [23:0] data_in,
    output logic        ready,
    output logic        done,
    output logic [63:0] codeword
);

    polar_enc_state_t state_q;
    logic [23:0] data_q;
    logic [15:0] crc_q, crc_d;
    logic [1:0]  cnt_q;
    logic [2:0]  stg_q;
    logic [63:0] x_q, x_d, u_map;
    logic [63:0] cw_q;
    logic        ready_q, done_q;
    logic        last_stg;
    logic [7:0]  byte_sel;

    always_comb begin
        case (cnt_q)
            2'd1:    byte_sel = data_q[15:8];
            2'd2:    byte_sel = data_q[7:0];
            default: byte_sel = data_q[23:16];
        endcase
    end

    crc16_ccitt_byte u_crc (
        .crc_i  (crc_q),
        .byte_i (byte_sel),
        .crc_o  (crc_d)
    );

    always_comb begin
        u_map = '0;
        for (int k = 0; k < K_DATA; k++)
            u_map[INFO_POS[k]] = data_q[K_DATA-1-k];
        for (int k = 0; k < K_CRC; k++)
            u_map[INFO_POS[K_DATA+k]] = crc_q[K_CRC-1-k];
    end

`ifdef POLAR64_ENC_FAST_XFORM_EN
    assign x_d      = polar_transform64(x_q);
    assign last_stg = 1'b1;
`else
    assign x_d      = polar_stage64(x_q, stg_q);
    assign last_stg = (stg_q == 3'd5);
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
            data_q  <= '0;
            crc_q   <= '0;
            cnt_q   <= '0;
            stg_q   <= '0;
            x_q     <= '0;
            cw_q    <= '0;
            ready_q <= 1'b1;
            done_q  <= 1'b0;
        end else begin
            done_q <= 1'b0;
            case (state_q)
                ST_IDLE: begin
                    if (start) begin
                        data_q  <= data_in;
                        crc_q   <= CRC_INIT;
                        cnt_q   <= '0;
                        ready_q <= 1'b0;
                        state_q <= ST_CRC;
                    end
                end
                ST_CRC: begin
                    crc_q <= crc_d;
                    cnt_q <= cnt_q + 2'd1;
                    if (cnt_q == 2'd2)
                        state_q <= ST_MAP;
                end
                ST_MAP: begin
                    x_q     <= u_map;
                    stg_q   <= '0;
                    state_q <= ST_XFORM;
                end
                ST_XFORM: begin
                    x_q   <= x_d;
                    stg_q <= stg_q + 3'd1;
                    if (last_stg) begin
                        cw_q    <= x_d;
                        done_q  <= 1'b1;
                        ready_q <= 1'b1;
                        state_q <= ST_IDLE;
                    end
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

    assign ready    = ready_q;
    assign done     = done_q;
    assign codeword = cw_q;

endmodule
